aes_scan_sequencer: RTL and testbench
=====================================

# aes_scan_sequencer

Sequencer between the SPI byte front-end and the static-key AES core with scan chain. It owns the core's `scan_enable`, `scan_in`, `load_i`, `dec_i` and `data_i`. While no command is running it parks the core by rotating the 144-bit chain, so the core state is frozen. It executes byte-level commands that:
- exchange the whole chain image,
- load a data block,
- run an exact number of functional clocks, or
- run until the core reports done.

## Interface
Parameters:
- `CHAIN_LEN`, 144: scan chain length in bits; must be a multiple of 8.
- `CHAIN_BYTES`, `CHAIN_LEN/8` = 18: bytes per chain image.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high. It is shared with the AES core.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  opcode: 0 SHIFT, 1 RUN, 2 LOAD, 3 RUN_TO_DONE.
- `cmd_arg`  in  8  opcode argument.
- `wr_valid`, `wr_ready`, `wr_data[7:0]`  in/out/in: write byte stream.
- `rd_valid`, `rd_ready`, `rd_data[7:0]`  out/in/out: read byte stream.
- `core_scan_enable`  out  1  drives the core's `scan_enable`.
- `core_scan_in`  out  1  drives the core's `scan_in`.
- `core_scan_out`  in  1  from the core's `scan_out`.
- `core_load`  out  1  drives the core's `load_i`.
- `core_dec`  out  1  drives the core's `dec_i`.
- `core_data`  out  128  drives the core's `data_i`.
- `core_done`  in  1  the core's `done_o`.
- `busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- **Parking.** When the FSM is not in a functional or scan-exchange window, `core_scan_enable=1` and `core_scan_in=core_scan_out`.
- **Rotation counter.** `rot` counts 0..CHAIN_LEN-1 and increments, with wrap, on every clock with `core_scan_enable=1`. It holds during functional cycles.
  - The chain is in its natural alignment iff `rot==0`.
  - Every SHIFT, RUN, LOAD and RUN_TO_DONE window starts only on a cycle with `rot==0` (ALIGN wait, 0..143 cycles).
- **FSM states:** IDLE, COLLECT, ALIGN, EXEC, EMIT.
- **SHIFT:**
  - COLLECT accepts 18 `wr` bytes into a 144-bit buffer, first byte at the MSB end.
  - ALIGN.
  - EXEC runs 144 consecutive scan cycles. `core_scan_in = buf[143]`, and the buffer shifts left with `core_scan_out` sampled into bit 0 at each edge.
  - EMIT sends 18 `rd` bytes, MSB end first.
  - Net effect: the old chain image is returned and the new one installed, with the same bit order for both.
- **RUN:**
  - ALIGN.
  - Exactly `cmd_arg+1` functional edges (1..256) with `core_scan_enable=0`.
  - No `rd` output.
- **LOAD:**
  - COLLECT accepts 16 `wr` bytes into `core_data`, first byte to [127:120].
  - `core_dec` is set to `cmd_arg[0]`.
  - ALIGN.
  - One functional edge with `core_load=1`.
  - `core_data` and `core_dec` hold until the next LOAD.
- **RUN_TO_DONE:**
  - ALIGN, then functional cycles.
  - `core_scan_enable = ~(exec & ~core_done)` combinationally, so no functional edge occurs once `core_done=1`.
  - Stops on `core_done=1` or after `cmd_arg+1` edges.
  - EMIT sends 2 bytes: status `{7'b0, done_seen}`, then (edge count − 1).
- Unused `cmd_op` values: none exist; all four opcodes are defined.
- `wr_ready` is high only in COLLECT. Surplus `wr` bytes outside COLLECT stall.

## Timing
- Reset values:
  - `cmd_ready=1`, `busy=0`, `rd_valid=0`, `rd_data=0`.
  - `wr_ready=0`, `core_load=0`, `core_dec=0`, `core_data=0`.
  - `core_scan_enable=1`, `core_scan_in=core_scan_out`.
  - `rot=0`, FSM=IDLE.
- `cmd_ready=1` only in IDLE. A command is accepted on the edge with `cmd_valid&cmd_ready`; `busy` rises the next cycle.
- From IDLE, commands with no byte input go straight to ALIGN.
- SHIFT exec window: exactly 144 cycles. After it `rot` is 0 again, because rot advances 144 times and wraps.
- EMIT:
  - `rd_data` is stable while `rd_valid=1 & rd_ready=0`.
  - Back-to-back bytes are allowed.
  - The chain keeps parking during EMIT stalls.
- Return to IDLE: one cycle after the last `rd` handshake, or one cycle after the last functional edge for RUN/LOAD.
- `rst` mid-operation: immediate abort to reset values. The core resets together, so alignment is consistent.

## Structure
- Package `aes_scan_pkg`:
  - opcode constants;
  - FSM state enum;
  - `CHAIN_LEN=144`, `DATA_BYTES=16`, `STATUS_BYTES=2`.
- Sub-module `aes_scan_buf`: 144-bit buffer with byte load (MSB-first), byte unload and a bit-serial exchange port. It is reused for SHIFT collect/emit.
- Top-level: FSM, `rot` counter, cycle counter (9 bits), LOAD data register.

## Test plan
- After reset, hold idle 1000 cycles, then SHIFT of all-zero bytes → returns 18×0x00. The core state is unchanged, as checked by a second SHIFT.
- Idle an arbitrary 37 cycles, SHIFT image A (0x01..0x12), idle 200 cycles, SHIFT zeros → returns exactly 0x01..0x12. This proves parking and alignment.
- LOAD `arg=0`, plaintext 00112233445566778899aabbccddeeff, then RUN_TO_DONE `arg=255` → status 0x01, count byte consistent with INIT+FIRST+10 rounds. A following SHIFT returns text field 69c4e0d86a7b0430d8cdb78070b4c55a.
- LOAD with `arg=1` and that ciphertext, then RUN_TO_DONE → the SHIFT-read text field equals the original plaintext.
- Fault injection: LOAD, RUN `arg=5`, SHIFT-read, modify one text bit, SHIFT-write, RUN_TO_DONE → completes with status 0x01, and the output differs from the golden value.
- Assert `rst` during a SHIFT EXEC at cycle 70 → `cmd_ready=1`, `rd_valid=0` on the next cycle. A subsequent SHIFT returns all zeros.

Source files
------------

// File: rtl/aes_scan_pkg.sv
// Shared constants and FSM encoding for the AES scan sequencer.
package aes_scan_pkg;

  localparam int CHAIN_LEN    = 144;
  localparam int DATA_BYTES   = 16;
  localparam int STATUS_BYTES = 2;

  localparam logic [1:0] OP_SHIFT = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_RTD   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ALIGN,
    ST_EXEC,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/aes_scan_buf.sv
// Chain-image buffer: byte load at the LSB end (first byte ends up at the MSB),
// byte unload from the MSB end, and a bit-serial exchange port on the MSB.
module aes_scan_buf #(
  parameter int W = 144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       unload,
  input  logic       xchg,
  input  logic       xchg_in,
  output logic       top_bit,
  output logic [7:0] top_byte
);

  logic [W-1:0] q;

  // One shift per cycle; the FSM never asserts two controls at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (load)   q <= {q[W-9:0], load_byte};
    else if (xchg)   q <= {q[W-2:0], xchg_in};
    else if (unload) q <= {q[W-9:0], 8'h00};
  end

  assign top_bit  = q[W-1];
  assign top_byte = q[W-1 -: 8];

endmodule

// File: rtl/aes_scan_sequencer.sv
// Command sequencer for the scan-chained AES core: parks the core by rotating
// its chain, tracks rotation so every window starts aligned, and executes
// SHIFT / RUN / LOAD / RUN_TO_DONE byte commands.
module aes_scan_sequencer #(
  parameter int CHAIN_LEN   = 144,
  parameter int CHAIN_BYTES = CHAIN_LEN / 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [7:0]   cmd_arg,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [7:0]   wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [7:0]   rd_data,
  output logic         core_scan_enable,
  output logic         core_scan_in,
  input  logic         core_scan_out,
  output logic         core_load,
  output logic         core_dec,
  output logic [127:0] core_data,
  input  logic         core_done,
  output logic         busy
);
  import aes_scan_pkg::*;

  localparam int RW = $clog2(CHAIN_LEN);
  localparam int BW = $clog2(CHAIN_BYTES + 1);

  state_t        state, state_nx;
  logic [1:0]    op;
  logic [7:0]    arg;
  logic [RW-1:0] rot;
  logic [8:0]    cnt;
  logic [BW-1:0] bcnt, last_in, last_out;
  logic          done_seen, at_wrap, enter_exec;
  logic          cmd_fire, wr_fire, rd_fire;
  logic          buf_bit;
  logic [7:0]    buf_byte, cnt_m1;

  // at_wrap: the next scan edge brings the chain back to natural alignment
  assign at_wrap    = (rot == RW'(CHAIN_LEN - 1));
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign wr_fire    = wr_valid & wr_ready;
  assign rd_fire    = rd_valid & rd_ready;
  assign last_in    = (op == OP_SHIFT) ? BW'(CHAIN_BYTES - 1) : BW'(DATA_BYTES - 1);
  assign last_out   = (op == OP_SHIFT) ? BW'(CHAIN_BYTES - 1) : BW'(STATUS_BYTES - 1);
  assign cnt_m1     = cnt[7:0] - 8'd1;
  assign busy       = (state != ST_IDLE);
  assign enter_exec = (state_nx == ST_EXEC) && (state != ST_EXEC);

  aes_scan_buf #(.W(CHAIN_LEN)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_fire && op == OP_SHIFT),
    .load_byte(wr_data),
    .unload   (rd_fire && op == OP_SHIFT),
    .xchg     (state == ST_EXEC && op == OP_SHIFT),
    .xchg_in  (core_scan_out),
    .top_bit  (buf_bit),
    .top_byte (buf_byte)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Rotation tracker: follows every scan edge the core sees, holds on functional edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   rot <= '0;
    else if (core_scan_enable) rot <= at_wrap ? '0 : rot + 1'b1;
  end

  // Next state and core/stream outputs; anything outside a window parks the chain.
  always_comb begin
    state_nx         = state;
    cmd_ready        = 1'b0;
    wr_ready         = 1'b0;
    rd_valid         = 1'b0;
    rd_data          = '0;
    core_scan_enable = 1'b1;
    core_scan_in     = core_scan_out;
    core_load        = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_SHIFT || cmd_op == OP_LOAD) state_nx = ST_COLLECT;
          else                                         state_nx = at_wrap ? ST_EXEC : ST_ALIGN;
        end
      end
      ST_COLLECT: begin
        wr_ready = 1'b1;
        if (wr_valid && bcnt == last_in) state_nx = at_wrap ? ST_EXEC : ST_ALIGN;
      end
      ST_ALIGN: if (at_wrap) state_nx = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_SHIFT: begin
            core_scan_in = buf_bit;
            if (cnt == 9'(CHAIN_LEN - 1)) state_nx = ST_EMIT;
          end
          OP_RUN: begin
            core_scan_enable = 1'b0;
            if (cnt[7:0] == arg) state_nx = ST_IDLE;
          end
          OP_LOAD: begin
            core_scan_enable = 1'b0;
            core_load        = 1'b1;
            state_nx         = ST_IDLE;
          end
          default: begin
            // a done core gets a scan edge instead of another functional edge
            core_scan_enable = core_done;
            if (core_done || cnt[7:0] == arg) state_nx = ST_EMIT;
          end
        endcase
      end
      ST_EMIT: begin
        rd_valid = 1'b1;
        if (op == OP_SHIFT)   rd_data = buf_byte;
        else if (bcnt == '0) rd_data = {7'b0, done_seen};
        else                  rd_data = cnt_m1;
        if (rd_ready && bcnt == last_out) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Command capture, byte/edge counters and the LOAD data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op        <= OP_SHIFT;
      arg       <= '0;
      cnt       <= '0;
      bcnt      <= '0;
      done_seen <= 1'b0;
      core_dec  <= 1'b0;
      core_data <= '0;
    end else begin
      if (cmd_fire) begin
        op   <= cmd_op;
        arg  <= cmd_arg;
        bcnt <= '0;
        if (cmd_op == OP_LOAD) core_dec <= cmd_arg[0];
      end
      if (wr_fire) begin
        bcnt <= bcnt + 1'b1;
        if (op == OP_LOAD) core_data <= {core_data[119:0], wr_data};
      end
      if (enter_exec) begin
        cnt       <= '0;
        done_seen <= 1'b0;
      end else if (state == ST_EXEC) begin
        if (op == OP_RTD && core_done) done_seen <= 1'b1;
        else                           cnt <= cnt + 1'b1;
        if (state_nx == ST_EMIT) bcnt <= '0;
      end
      if (rd_fire) bcnt <= bcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_scan_sequencer.sv
// Bench for aes_scan_sequencer with a toy scan-chained core: chain image is
// {text[127:0], round[7:0], flags[7:0]}, flags[0] = decrypt, done = round>=11.
module tb_aes_scan_sequencer;
  import aes_scan_pkg::*;

  localparam logic [127:0] KEY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [1:0]   cmd_op = 2'd0;
  logic [7:0]   cmd_arg = 8'd0;
  logic         wr_valid = 1'b0, wr_ready;
  logic [7:0]   wr_data = 8'd0;
  logic         rd_valid, rd_ready = 1'b0;
  logic [7:0]   rd_data;
  logic         core_scan_enable, core_scan_in, core_scan_out;
  logic         core_load, core_dec, core_done, busy;
  logic [127:0] core_data;

  always #5 clk = ~clk;

  aes_scan_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .core_scan_enable(core_scan_enable), .core_scan_in(core_scan_in),
    .core_scan_out(core_scan_out), .core_load(core_load), .core_dec(core_dec),
    .core_data(core_data), .core_done(core_done), .busy(busy)
  );

  // one functional round of the toy cipher (invertible, 11 rounds to done)
  function automatic logic [143:0] core_step(input logic [143:0] c);
    logic [127:0] t;
    if (c[15:8] >= 8'd11) return c;
    t = c[143:16];
    if (c[0]) t = {t[0], t[127:1]} ^ KEY;
    else begin
      t = t ^ KEY;
      t = {t[126:0], t[127]};
    end
    return {t, c[15:8] + 8'd1, c[7:0]};
  endfunction

  function automatic logic [143:0] run_core(input logic [143:0] c, input int n);
    logic [143:0] r;
    r = c;
    for (int i = 0; i < n; i++) r = core_step(r);
    return r;
  endfunction

  // toy core: shift register when scanning, cipher round or load otherwise
  logic [143:0] chain;
  int           tb_rot;
  assign core_scan_out = chain[143];
  assign core_done     = (chain[15:8] >= 8'd11);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      chain  <= '0;
      tb_rot <= 0;
    end else if (core_scan_enable) begin
      chain  <= {chain[142:0], core_scan_in};
      tb_rot <= (tb_rot + 1) % 144;
    end else if (core_load) chain <= {core_data, 8'd0, 7'd0, core_dec};
    else chain <= core_step(chain);
  end

  int n_cmp = 0, n_fail = 0, park_bad = 0, stall_bad = 0, rd_bad = 0;

  task automatic chk(input string name, input logic [143:0] got, input logic [143:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out, got no DUT response, required one", name);
  endtask

  // reference: abstract aligned chain image, command semantics only
  logic [143:0] ref_img = '0;
  task automatic ref_apply(input logic [1:0] op, input logic [7:0] arg, input logic [143:0] w,
                           output logic [143:0] e, output int n);
    int  k;
    bit  ds;
    e = '0;
    n = 0;
    case (op)
      OP_SHIFT: begin e = ref_img; ref_img = w; n = 18; end
      OP_RUN:   for (int i = 0; i <= int'(arg); i++) ref_img = core_step(ref_img);
      OP_LOAD:  ref_img = {w[143:16], 8'd0, 7'd0, arg[0]};
      default: begin
        k = 0;
        ds = 0;
        while (1) begin
          if (ref_img[15:8] >= 8'd11) begin ds = 1; break; end
          ref_img = core_step(ref_img);
          k++;
          if (k == int'(arg) + 1) break;
        end
        e = {128'b0, 7'b0, ds, 8'(k - 1)};
        n = 2;
      end
    endcase
  endtask

  task automatic do_cmd(input string name, input logic [1:0] op, input logic [7:0] arg,
                        input int idle, input logic [143:0] w, input int nexp,
                        output logic [143:0] got);
    int         nwr, t, k;
    logic       pstall;
    logic [7:0] pdata;
    got = '0;
    repeat (idle) begin
      @(negedge clk);
      if (!core_scan_enable || core_scan_in !== core_scan_out) park_bad++;
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; t = 0;
    while (!cmd_ready && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) begin cmd_valid = 1'b0; fail_to({name, "_cmd"}); return; end
    @(negedge clk);
    cmd_valid = 1'b0;
    nwr = (op == OP_SHIFT) ? 18 : (op == OP_LOAD) ? 16 : 0;
    for (int i = 0; i < nwr; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      wr_valid = 1'b1; wr_data = w[143-8*i -: 8]; t = 0;
      while (!wr_ready && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) begin wr_valid = 1'b0; fail_to({name, "_wr"}); return; end
      @(negedge clk);
      wr_valid = 1'b0;
    end
    t = 0; k = 0; pstall = 0; pdata = '0;
    while (k < nexp && t < 3000) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      if (pstall && rd_data !== pdata) stall_bad++;
      pstall = rd_valid && !rd_ready;
      pdata  = rd_data;
      if (rd_valid && rd_ready) begin got = {got[135:0], rd_data}; k++; end
      @(negedge clk);
      t++;
    end
    rd_ready = 1'b0;
    if (k < nexp) fail_to({name, "_rd"});
    if (nexp == 0) begin
      t = 0;
      while (busy && t < 3000) begin
        if (rd_valid) rd_bad++;
        @(negedge clk);
        t++;
      end
      if (busy) fail_to({name, "_done"});
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [7:0]   arg;
    int           idle;
    logic [143:0] w;
    int           nexp;
    logic [143:0] e;
    string        name;
  } vec_t;
  vec_t tbl[22];

  task automatic set_vec(input int i, input logic [1:0] op, input logic [7:0] arg, input int idle,
                         input logic [143:0] w, input int nexp, input logic [143:0] e,
                         input string name);
    tbl[i].op = op; tbl[i].arg = arg; tbl[i].idle = idle; tbl[i].w = w;
    tbl[i].nexp = nexp; tbl[i].e = e; tbl[i].name = name;
  endtask

  initial begin
    logic [143:0] img_a, golden, mid, faulty, fout, got, e;
    logic [1:0]   op;
    logic [7:0]   arg;
    int           n, t;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_core_load", core_load, 0);
    chk("rst_core_dec", core_dec, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_scan_enable", core_scan_enable, 1);
    chk("rst_scan_loop", core_scan_in, core_scan_out);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) img_a[143-8*i -: 8] = 8'(i + 1);
    golden = run_core({PT, 16'h0000}, 11);
    mid    = run_core({PT, 16'h0000}, 6);
    faulty = mid ^ (144'd1 << 100);
    fout   = run_core(faulty, 5);

    set_vec( 0, OP_SHIFT, 0,   1000, '0,                   18, '0,                     "shift_zero_parked");
    set_vec( 1, OP_SHIFT, 0,   0,    '0,                   18, '0,                     "shift_zero_again");
    set_vec( 2, OP_SHIFT, 0,   37,   img_a,                18, '0,                     "shift_write_a");
    set_vec( 3, OP_SHIFT, 0,   200,  '0,                   18, img_a,                  "shift_read_a");
    set_vec( 4, OP_LOAD,  0,   3,    {PT, 16'h0},          0,  '0,                     "load_pt");
    set_vec( 5, OP_RTD,   255, 0,    '0,                   2,  144'h010a,              "rtd_enc");
    set_vec( 6, OP_SHIFT, 0,   5,    '0,                   18, golden,                 "shift_ct");
    set_vec( 7, OP_LOAD,  1,   0,    {golden[143:16], 16'h0}, 0, '0,                   "load_ct");
    set_vec( 8, OP_RTD,   255, 0,    '0,                   2,  144'h010a,              "rtd_dec");
    set_vec( 9, OP_SHIFT, 0,   0,    '0,                   18, {PT, 8'd11, 8'h01},     "shift_pt");
    set_vec(10, OP_LOAD,  0,   0,    {PT, 16'h0},          0,  '0,                     "load_pt2");
    set_vec(11, OP_RUN,   5,   0,    '0,                   0,  '0,                     "run6");
    set_vec(12, OP_SHIFT, 0,   0,    faulty,               18, mid,                    "shift_fault");
    set_vec(13, OP_RTD,   255, 0,    '0,                   2,  144'h0104,              "rtd_fault");
    set_vec(14, OP_SHIFT, 0,   0,    '0,                   18, fout,                   "shift_faulty_ct");
    set_vec(15, OP_LOAD,  0,   0,    {PT, 16'h0},          0,  '0,                     "load_pt3");
    set_vec(16, OP_RTD,   3,   0,    '0,                   2,  144'h0003,              "rtd_limit4");
    set_vec(17, OP_RTD,   0,   0,    '0,                   2,  144'h0000,              "rtd_limit1");
    set_vec(18, OP_RTD,   255, 0,    '0,                   2,  144'h0105,              "rtd_finish");
    set_vec(19, OP_RTD,   7,   0,    '0,                   2,  144'h01ff,              "rtd_already_done");
    set_vec(20, OP_RUN,   255, 0,    '0,                   0,  '0,                     "run256");
    set_vec(21, OP_SHIFT, 0,   0,    '0,                   18, golden,                 "shift_final");

    for (int i = 0; i < 22; i++) begin
      do_cmd(tbl[i].name, tbl[i].op, tbl[i].arg, tbl[i].idle, tbl[i].w, tbl[i].nexp, got);
      if (tbl[i].nexp > 0) chk(tbl[i].name, got, tbl[i].e);
      if (i == 14) begin
        n_cmp++;
        if (got[143:16] === golden[143:16]) begin
          n_fail++;
          $display("FAIL fault_differs: got %h required a value other than %h", got[143:16], golden[143:16]);
        end
      end
    end
    chk("idle_parking", park_bad, 0);

    // reset in the middle of a SHIFT exchange window
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_SHIFT; cmd_arg = 0; t = 0;
    while (!cmd_ready && t < 3000) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 1); t = 0;
      while (!wr_ready && t < 3000) begin @(negedge clk); t++; end
      @(negedge clk);
      wr_valid = 1'b0;
    end
    t = 0;
    while (tb_rot != 0 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) fail_to("mid_rst_align");
    repeat (70) @(negedge clk);
    chk("mid_rst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    ref_img = '0;
    do_cmd("after_rst_shift", OP_SHIFT, 0, 3, '0, 18, got);
    chk("after_rst_shift", got, '0);

    // randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      got = {$urandom, $urandom, $urandom, $urandom, 16'h0};
      got[15:8] = 8'($urandom_range(0, 14));
      got[0]    = 1'($urandom_range(0, 1));
      case (op)
        OP_RUN:  arg = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 30));
        OP_RTD:  arg = 8'($urandom_range(0, 15));
        OP_LOAD: arg = 8'($urandom_range(0, 255));
        default: arg = 8'd0;
      endcase
      ref_apply(op, arg, got, e, n);
      do_cmd($sformatf("rand%0d_op%0d", i, op), op, arg, $urandom_range(0, 20), got, n, got);
      if (n > 0) chk($sformatf("rand%0d_op%0d", i, op), got, e);
    end

    chk("rd_stall_stable", stall_bad, 0);
    chk("no_rd_on_run_load", rd_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
